fault_dict_sequencer: RTL
=========================

Name: fault_dict_sequencer

Overview:
- Synthesizable controller that runs fault-dictionary generation in hardware emulation, replacing the behavioural fault-simulation loop.
- For each collapsed fault it injects the fault into the faulty CUT copy, applies every test pattern to the good and faulty copies, and compares their outputs to build a per-fault syndrome.
- It then emits a dictionary record, removes the fault, and keeps a detected-fault count for coverage.
- It sits between the pattern buffer, the fault-injection harness, both CUT instances and the dictionary sink.

Parameters:
- OUT_W, 64, width of the CUT primary-output vector.
- N_PAT, 129, number of test patterns; this is also the syndrome width.
- N_FLT, 1798, number of collapsed faults.
- PAT_AW, 8, pattern address width (2^PAT_AW >= N_PAT).
- FLT_AW, 11, fault index width (2^FLT_AW >= N_FLT).
- SETTLE, 2, number of cycles the CUT outputs settle after a pattern load (>=1).

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, one-cycle pulse that starts a run; honoured only in IDLE or DONE.
- busy, output, 1, high in every state except IDLE and DONE.
- done, output, 1, high in DONE.
- inj_active, output, 1, fault-injection request level (4-phase handshake).
- inj_idx, output, FLT_AW, index of the fault to inject; stable while inj_active=1.
- inj_ack, input, 1, harness acknowledge; follows inj_active.
- pat_addr, output, PAT_AW, pattern buffer address.
- pat_load, output, 1, one-cycle strobe; the buffer drives pattern[pat_addr] to both CUTs on the next edge.
- good_out, input, OUT_W, golden CUT outputs.
- faulty_out, input, OUT_W, faulty CUT outputs.
- dict_valid, output, 1, dictionary record valid.
- dict_ready, input, 1, sink ready.
- dict_idx, output, FLT_AW, fault index of the record.
- dict_syndrome, output, N_PAT, syndrome of the record; bit i is 1 when pattern i detected the fault.
- det_cnt, output, FLT_AW+1, number of faults with a non-zero syndrome.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. With rst_n=0 at a clk edge, all state clears.
- Reset values: state=IDLE; busy=0, done=0, inj_active=0, pat_load=0, dict_valid=0; pat_addr=0, inj_idx=0, dict_idx=0, dict_syndrome=0, det_cnt=0.
- Reset mid-run aborts at once: inj_active drops on the same edge, and there is no dictionary write or count update.
- FSM states: IDLE, INJECT, PAT_RD, SETTLE, COMPARE, DICT_WR, REMOVE, DONE.
- IDLE/DONE + start: flt_idx=0, det_cnt=0, go to INJECT. start is ignored in all other states.
- INJECT (entry):
  - inj_active=1, inj_idx=flt_idx.
  - pat_idx=0, syndrome=0.
  - Wait in the state until inj_ack=1, then go to PAT_RD.
- PAT_RD: pat_addr=pat_idx and pat_load=1 for exactly one cycle, then go to SETTLE.
- SETTLE: stay SETTLE cycles (down-counter), then go to COMPARE.
- COMPARE (one cycle):
  - syndrome[pat_idx] = (good_out != faulty_out), i.e. the full OUT_W-bit compare.
  - If pat_idx==N_PAT-1, go to DICT_WR; otherwise pat_idx++ and go to PAT_RD.
  - Per-pattern cost is SETTLE+2 cycles.
- DICT_WR:
  - dict_valid=1; dict_idx=flt_idx and dict_syndrome=syndrome, both held stable while dict_valid=1.
  - Transfer happens on a cycle where dict_valid and dict_ready are both 1. On that edge, det_cnt++ if syndrome!=0, dict_valid drops, and the FSM goes to REMOVE.
  - dict_ready asserted before dict_valid is allowed; the transfer then takes the first DICT_WR cycle.
- REMOVE:
  - inj_active=0; wait in the state until inj_ack=0.
  - Then: if flt_idx==N_FLT-1, go to DONE; otherwise flt_idx++ and go to INJECT.
  - The fault stays injected through dictionary emission.
- DONE: done=1; det_cnt and the last dict_* values are held until the next start or reset.
- inj_idx changes only while inj_active=0.
- pat_load is never asserted while inj_active=0 or inj_ack=0.
- Counters never wrap: pat_idx ranges 0..N_PAT-1, flt_idx 0..N_FLT-1, det_cnt 0..N_FLT.
- Undetected faults still produce a record, with an all-zero syndrome.

Test Plan:
- Parameters for all scenarios: N_PAT=4, N_FLT=3, SETTLE=2, OUT_W=8. Harness acks after 1 cycle; sink is always ready.
- Reset/idle: rst_n=0 then 1, no start → busy=0, done=0, inj_active=0, dict_valid=0, det_cnt=0 for 20 cycles.
- Full run:
  - faulty_out differs from good_out only for fault 1 on patterns 0 and 3.
  - Expect records (0,4'b0000), (1,4'b1001), (2,4'b0000) in order, then done=1 and det_cnt=1.
  - Expect 12 pat_load pulses, each followed by 3 cycles before the next pat_load.
- Backpressure: dict_ready low for 5 cycles on fault 0 → dict_valid held, dict_idx=0 and syndrome stable, no REMOVE until dict_ready=1; det_cnt counted once.
- Slow harness: inj_ack delayed 4 cycles on assert and on deassert → no pat_load before inj_ack=1; inj_idx stable; next INJECT only after inj_ack=0.
- Abort and ignored start: rst_n=0 during SETTLE of fault 1 → next cycle state IDLE, inj_active=0, det_cnt=0. start pulsed mid-run → no effect. start in DONE → run restarts from fault 0 with det_cnt cleared.

Source files
------------

// File: rtl/fault_dict_sequencer.sv
// ============================================================================
// Module   : fault_dict_sequencer
// Purpose  : Emulation-side fault-dictionary generator: injects each collapsed
//            fault, replays all patterns on good/faulty CUTs, emits syndromes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fault_dict_sequencer #(
    parameter int OUT_W  = 64,
    parameter int N_PAT  = 129,
    parameter int N_FLT  = 1798,
    parameter int PAT_AW = 8,
    parameter int FLT_AW = 11,
    parameter int SETTLE = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              inj_active_o,
    output logic [FLT_AW-1:0] inj_idx_o,
    input  logic              inj_ack_i,
    output logic [PAT_AW-1:0] pat_addr_o,
    output logic              pat_load_o,
    input  logic [OUT_W-1:0]  good_out_i,
    input  logic [OUT_W-1:0]  faulty_out_i,
    output logic              dict_valid_o,
    input  logic              dict_ready_i,
    output logic [FLT_AW-1:0] dict_idx_o,
    output logic [N_PAT-1:0]  dict_syndrome_o,
    output logic [FLT_AW:0]   det_cnt_o
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [PAT_AW-1:0] LAST_PAT = PAT_AW'(N_PAT - 1);
    localparam logic [FLT_AW-1:0] LAST_FLT = FLT_AW'(N_FLT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INJECT  = 3'd1,
        S_PAT_RD  = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_DICT_WR = 3'd5,
        S_REMOVE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t             state_q;
    logic [FLT_AW-1:0]  flt_idx_q;
    logic [PAT_AW-1:0]  pat_idx_q;
    logic [CNT_W-1:0]   settle_cnt_q;
    logic [N_PAT-1:0]   syndrome_q;
    logic [N_PAT-1:0]   syndrome_d;
    logic               inj_active_q;
    logic [FLT_AW-1:0]  inj_idx_q;
    logic [PAT_AW-1:0]  pat_addr_q;
    logic               pat_load_q;
    logic               dict_valid_q;
    logic [FLT_AW-1:0]  dict_idx_q;
    logic [N_PAT-1:0]   dict_syn_q;
    logic [FLT_AW:0]    det_cnt_q;

    // Syndrome with the current pattern's detection bit folded in.
    always_comb begin
        syndrome_d            = syndrome_q;
        syndrome_d[pat_idx_q] = (good_out_i != faulty_out_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            flt_idx_q    <= '0;
            pat_idx_q    <= '0;
            settle_cnt_q <= '0;
            syndrome_q   <= '0;
            inj_active_q <= 1'b0;
            inj_idx_q    <= '0;
            pat_addr_q   <= '0;
            pat_load_q   <= 1'b0;
            dict_valid_q <= 1'b0;
            dict_idx_q   <= '0;
            dict_syn_q   <= '0;
            det_cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        flt_idx_q    <= '0;
                        det_cnt_q    <= '0;
                        inj_active_q <= 1'b1;
                        inj_idx_q    <= '0;
                        pat_idx_q    <= '0;
                        syndrome_q   <= '0;
                        state_q      <= S_INJECT;
                    end
                end
                S_INJECT: begin
                    if (inj_ack_i) begin
                        pat_addr_q <= pat_idx_q;
                        pat_load_q <= 1'b1;
                        state_q    <= S_PAT_RD;
                    end
                end
                S_PAT_RD: begin
                    pat_load_q   <= 1'b0;
                    settle_cnt_q <= CNT_W'(SETTLE - 1);
                    state_q      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_q <= S_COMPARE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end
                end
                S_COMPARE: begin
                    syndrome_q <= syndrome_d;
                    if (pat_idx_q == LAST_PAT) begin
                        dict_valid_q <= 1'b1;
                        dict_idx_q   <= flt_idx_q;
                        dict_syn_q   <= syndrome_d;
                        state_q      <= S_DICT_WR;
                    end else begin
                        pat_idx_q  <= pat_idx_q + 1'b1;
                        pat_addr_q <= pat_idx_q + 1'b1;
                        pat_load_q <= 1'b1;
                        state_q    <= S_PAT_RD;
                    end
                end
                S_DICT_WR: begin
                    // Fault remains injected until the record has been accepted.
                    if (dict_ready_i) begin
                        dict_valid_q <= 1'b0;
                        inj_active_q <= 1'b0;
                        if (syndrome_q != '0) begin
                            det_cnt_q <= det_cnt_q + 1'b1;
                        end
                        state_q <= S_REMOVE;
                    end
                end
                S_REMOVE: begin
                    if (!inj_ack_i) begin
                        if (flt_idx_q == LAST_FLT) begin
                            state_q <= S_DONE;
                        end else begin
                            flt_idx_q    <= flt_idx_q + 1'b1;
                            inj_idx_q    <= flt_idx_q + 1'b1;
                            inj_active_q <= 1'b1;
                            pat_idx_q    <= '0;
                            syndrome_q   <= '0;
                            state_q      <= S_INJECT;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o          = (state_q == S_DONE);
    assign inj_active_o    = inj_active_q;
    assign inj_idx_o       = inj_idx_q;
    assign pat_addr_o      = pat_addr_q;
    assign pat_load_o      = pat_load_q;
    assign dict_valid_o    = dict_valid_q;
    assign dict_idx_o      = dict_idx_q;
    assign dict_syndrome_o = dict_syn_q;
    assign det_cnt_o       = det_cnt_q;

endmodule

`default_nettype wire
